// File: rtl/ccff_loader.sv
`timescale 1ns/1ps
// Purpose : loads a configuration-flip-flop chain from a word stream, MSB first, with an optional parity readback.
// Latency : a word accepted on edge t drives its bits in cycles t+1..t+WORD_W; done pulses one cycle after the last bit
//           (after the extra CHAIN_LEN-cycle VERIFY pass when readback is built in).
// Backpr. : cfg_ready is high only in FETCH; FETCH waits indefinitely for cfg_valid, and the chain does not shift meanwhile.
//
// Optional feature: define CCFF_READBACK_EN to add the VERIFY recirculation pass and parity compare (drives err).
//
// Ports:
//   prog_clk, prog_reset   clock and asynchronous active-high reset
//   start, abort           load request (sampled in IDLE) / synchronous cancel (any non-IDLE state)
//   cfg_data, cfg_valid,   bitstream word handshake
//   cfg_ready
//   ccff_head, ccff_tail   chain head (driven) and chain tail (observed)
//   shift_en               chain clock enable, one chain bit per high cycle
//   busy, done, err        status: not IDLE / one-cycle completion / readback parity mismatch
module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_W + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef CCFF_READBACK_EN
  localparam logic [2:0] S_VERIFY = 3'd3;
`endif

  logic [2:0]        state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              head_q;   // last bit put on the chain; held while not shifting

  logic last_bit;
  logic word_end;
  logic msb;

  assign msb      = sreg_q[WORD_W-1];
  // The bit being driven now is the final one of the chain: leave SHIFT even mid-word.
  assign last_bit = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign word_end = (wcnt_q == WCNT_W'(WORD_W - 1));

`ifdef CCFF_READBACK_EN
  logic [CNT_W-1:0] ver_cnt_q;
  logic             par_drv_q;
  logic             par_tail_q;
  logic             err_q;
  logic             ver_last;

  assign ver_last = (ver_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign err      = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      wcnt_q     <= '0;
      head_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
      ver_cnt_q  <= '0;
      par_drv_q  <= 1'b0;
      par_tail_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else if (state_q != S_IDLE && abort) begin
      // Abort wins over a simultaneous handshake or completion.
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            bit_cnt_q <= '0;
`ifdef CCFF_READBACK_EN
            err_q      <= 1'b0;
            par_drv_q  <= 1'b0;
            par_tail_q <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (cfg_valid) begin
            sreg_q  <= cfg_data;
            wcnt_q  <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sreg_q    <= sreg_q << 1;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          wcnt_q    <= wcnt_q + WCNT_W'(1);
          head_q    <= msb;
`ifdef CCFF_READBACK_EN
          par_drv_q <= par_drv_q ^ msb;
`endif
          if (last_bit) begin
`ifdef CCFF_READBACK_EN
            state_q   <= S_VERIFY;
            ver_cnt_q <= '0;
`else
            state_q   <= S_DONE;
`endif
          end else if (word_end) begin
            state_q <= S_FETCH;
          end
        end
`ifdef CCFF_READBACK_EN
        S_VERIFY: begin
          // Tail is fed back to head, so after CHAIN_LEN cycles the chain holds its original contents.
          ver_cnt_q  <= ver_cnt_q + CNT_W'(1);
          par_tail_q <= par_tail_q ^ ccff_tail;
          head_q     <= ccff_tail;
          if (ver_last) begin
            // Fold in the tail bit of this final cycle, which the parity register has not seen yet.
            err_q   <= par_drv_q ^ par_tail_q ^ ccff_tail;
            state_q <= S_DONE;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state_q == S_FETCH);
    shift_en  = (state_q == S_SHIFT);
    ccff_head = head_q;
    if (state_q == S_SHIFT) begin
      ccff_head = msb;
    end
`ifdef CCFF_READBACK_EN
    if (state_q == S_VERIFY) begin
      shift_en  = 1'b1;
      ccff_head = ccff_tail;
    end
`endif
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_ccff_loader.sv
`timescale 1ns/1ps
// Bench for ccff_loader: two instances (64-bit and 20-bit chains, 8-bit words) each drive a behavioural chain
// model. Expected head bits are queued when a load is issued; a negedge monitor pops and compares them.
module tb_ccff_loader;
  localparam int W  = 8;
  localparam int L0 = 64;
  localparam int L1 = 20;
`ifdef CCFF_READBACK_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_s [2];
  logic         abort_s [2];
  logic         valid_s [2];
  logic [W-1:0] data_s  [2];
  logic         ready_o [2];
  logic         head_o  [2];
  logic         sh_o    [2];
  logic         busy_o  [2];
  logic         done_o  [2];
  logic         err_o   [2];
  logic         tail0, tail1;

  logic [63:0] chain [2] = '{64'd0, 64'd0};
  int          sh_cnt   [2];
  int          done_cnt [2];
  bit          prev_done[2];
  bit          flip_req [2];
  logic [63:0] exp_vec  [2];
  bit          exp_q0[$];
  bit          exp_q1[$];
  logic [W-1:0] wbuf [8];
  int checks   = 0;
  int failures = 0;

  assign tail0 = chain[0][L0-1];
  assign tail1 = chain[1][L1-1];

  ccff_loader #(.CHAIN_LEN(L0), .WORD_W(W)) dut0 (
    .prog_clk(clk), .prog_reset(rst), .start(start_s[0]), .abort(abort_s[0]),
    .cfg_data(data_s[0]), .cfg_valid(valid_s[0]), .cfg_ready(ready_o[0]),
    .ccff_head(head_o[0]), .ccff_tail(tail0), .shift_en(sh_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  ccff_loader #(.CHAIN_LEN(L1), .WORD_W(W)) dut1 (
    .prog_clk(clk), .prog_reset(rst), .start(start_s[1]), .abort(abort_s[1]),
    .cfg_data(data_s[1]), .cfg_valid(valid_s[1]), .cfg_ready(ready_o[1]),
    .ccff_head(head_o[1]), .ccff_tail(tail1), .shift_en(sh_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  function automatic int len_of(input int g);
    return (g == 0) ? L0 : L1;
  endfunction

  function automatic int qsize(input int g);
    return (g == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic bit qpop(input int g);
    if (g == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void qpush(input int g, input bit b);
    if (g == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int lim);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required_limit=%0d", name, act, lim);
  endtask

  // Behavioural chain: shifts toward the tail whenever shift_en is high; optionally corrupts one
  // bit that the readback pass has yet to observe.
  always @(posedge clk) begin
    int lg;
    for (int g = 0; g < 2; g++) begin
      lg = len_of(g);
      if (start_s[g] && !busy_o[g]) begin
        sh_cnt[g] = 0;
      end else if (sh_o[g]) begin
        chain[g]  = {chain[g][62:0], head_o[g]};
        sh_cnt[g] = sh_cnt[g] + 1;
        if (flip_req[g] && sh_cnt[g] == lg + 1) chain[g][lg-1] = ~chain[g][lg-1];
      end
    end
  end

  // Monitor: every shift cycle must match the next queued bit; done is checked against shift count and chain.
  always @(negedge clk) begin
    int          lg;
    logic [63:0] mask;
    for (int g = 0; g < 2; g++) begin
      lg   = len_of(g);
      mask = (64'd1 << lg) - 64'd1;
      if (sh_o[g]) begin
        if (sh_cnt[g] < lg) begin
          if (qsize(g) == 0) fail("unexpected_shift", sh_cnt[g], lg);
          else               chk("head_bit", head_o[g], qpop(g));
`ifdef CCFF_READBACK_EN
        end else if (sh_cnt[g] < 2 * lg) begin
          chk("verify_recirc", head_o[g], (g == 0) ? tail0 : tail1);
`endif
        end else begin
          fail("extra_shift", sh_cnt[g], PASSES * lg);
        end
      end
      if (prev_done[g]) chk("busy_after_done", busy_o[g], 1'b0);
      prev_done[g] = done_o[g];
      if (done_o[g]) begin
        done_cnt[g]++;
        chk("shift_count", sh_cnt[g], PASSES * lg);
        chk("err_at_done", err_o[g], flip_req[g]);
        if (!flip_req[g]) chk("chain_contents", chain[g] & mask, exp_vec[g]);
      end
    end
  end

  task automatic rand_words();
    for (int i = 0; i < 8; i++) wbuf[i] = W'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_word(input int g, input logic [W-1:0] w, input int stall);
    int n;
    data_s[g] = w;
    if (stall > 0) begin
      valid_s[g] = 1'b0;
      n = 0;
      while (!ready_o[g] && n < 200) begin @(negedge clk); n++; end
      if (!ready_o[g]) fail("fetch_wait", n, 200);
      for (int k = 0; k < stall; k++) begin
        chk("stall_ready", ready_o[g], 1'b1);
        chk("stall_no_shift", sh_o[g], 1'b0);
        @(negedge clk);
      end
    end
    valid_s[g] = 1'b1;
    n = 0;
    while (!ready_o[g] && n < 200) begin @(negedge clk); n++; end
    if (!ready_o[g]) begin
      fail("handshake_wait", n, 200);
      return;
    end
    @(negedge clk);
    chk("first_bit_next_cycle", sh_o[g], 1'b1);
  endtask

  // kill_at >= 0 cancels the load once kill_at bits have shifted: by abort, or by reset when kill_rst.
  task automatic load(input int g, input int stall_at, input int stall_len,
                      input int kill_at, input bit kill_rst, input bit poke_start);
    int lg, nw, idx, n, dc0;
    lg = len_of(g);
    nw = (lg + W - 1) / W;
    if (g == 0) exp_q0.delete(); else exp_q1.delete();
    exp_vec[g] = '0;
    idx = 0;
    for (int wi = 0; wi < nw; wi++) begin
      for (int b = W - 1; b >= 0; b--) begin
        if (idx < lg) begin
          qpush(g, wbuf[wi][b]);
          exp_vec[g][lg-1-idx] = wbuf[wi][b];
          idx++;
        end
      end
    end
    dc0 = done_cnt[g];
    valid_s[g] = 1'b0;
    @(negedge clk); start_s[g] = 1'b1;
    @(negedge clk); start_s[g] = 1'b0;
    chk("busy_after_start", busy_o[g], 1'b1);
    chk("err_cleared_on_start", err_o[g], 1'b0);
    for (int wi = 0; wi < nw; wi++) begin
      if (kill_at >= 0 && wi * W > kill_at) break;
      send_word(g, wbuf[wi], (wi == stall_at) ? stall_len : 0);
      if (poke_start && wi == 1) begin
        start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
      end
    end
    valid_s[g] = 1'b0;
    if (kill_at >= 0) begin
      n = 0;
      while (sh_cnt[g] != kill_at && n < 200) begin @(negedge clk); n++; end
      if (sh_cnt[g] != kill_at) fail("kill_point_wait", sh_cnt[g], kill_at);
      if (kill_rst) begin
        #2 rst = 1'b1;
        #1 chk("reset_outputs_immediate",
               {ready_o[g], head_o[g], sh_o[g], busy_o[g], done_o[g], err_o[g]}, 6'b0);
        @(negedge clk) rst = 1'b0;
      end else begin
        abort_s[g] = 1'b1;
        @(negedge clk);
        abort_s[g] = 1'b0;
        chk("abort_idle", busy_o[g], 1'b0);
        chk("abort_no_shift", sh_o[g], 1'b0);
      end
      repeat (4) @(negedge clk);
      chk("killed_no_done", done_cnt[g] - dc0, 0);
      return;
    end
    n = 0;
    while (done_cnt[g] == dc0 && n < 400) begin @(negedge clk); n++; end
    if (done_cnt[g] == dc0) fail("done_wait", n, 400);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt[g] - dc0, 1);
    chk("all_bits_driven", qsize(g), 0);
    chk("idle_not_busy", busy_o[g], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      abort_s[g] = 1'b0;
      valid_s[g] = 1'b0;
      data_s[g]  = '0;
    end
    #12;
    for (int g = 0; g < 2; g++)
      chk("reset_state", {ready_o[g], head_o[g], sh_o[g], busy_o[g], done_o[g], err_o[g]}, 6'b0);
    @(negedge clk) rst = 1'b0;

    // 64-bit chain, constant 0xA5 words with valid held high
    for (int i = 0; i < 8; i++) wbuf[i] = 8'hA5;
    load(0, -1, 0, -1, 1'b0, 1'b0);

    // 20-bit chain: last word truncated after its upper nibble
    wbuf[0] = 8'hFF; wbuf[1] = 8'h00; wbuf[2] = 8'hF0;
    load(1, -1, 0, -1, 1'b0, 1'b0);

    // 5-cycle valid gap in FETCH, plus a start pulse while busy
    rand_words();
    load(0, 3, 5, -1, 1'b0, 1'b1);

    // abort at bit 30, then a full reload
    rand_words();
    load(0, -1, 0, 30, 1'b0, 1'b0);
    rand_words();
    load(0, -1, 0, -1, 1'b0, 1'b0);

    // reset mid-shift, then a full reload
    rand_words();
    load(0, -1, 0, 13, 1'b1, 1'b0);
    rand_words();
    load(0, -1, 0, -1, 1'b0, 1'b0);

    // randomized loads on both chains
    for (int it = 0; it < 6; it++) begin
      rand_words();
      load(it % 2, int'($urandom_range(0, 7)), int'($urandom_range(1, 6)), -1, 1'b0, 1'($urandom_range(0, 1)));
    end

`ifdef CCFF_READBACK_EN
    // corrupted chain during readback must flag err, and err holds until the next start
    rand_words();
    flip_req[0] = 1'b1;
    load(0, -1, 0, -1, 1'b0, 1'b0);
    chk("err_held_in_idle", err_o[0], 1'b1);
    flip_req[0] = 1'b0;
    rand_words();
    load(0, -1, 0, -1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64, SHALL set the configuration chain length in bits (16 muxes x 4 SRAM bits); legal range 1..4096.
REQ-002 Parameter WORD_W, default 8, SHALL set the input word width; legal range 1..32.
REQ-003 prog_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 prog_reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  in  1  SHALL be a load request, sampled only in IDLE.
REQ-006 abort  in  1  SHALL be a synchronous cancel, valid in any non-IDLE state.
REQ-007 cfg_data  in  WORD_W  SHALL be the bitstream word.
REQ-008 cfg_valid  in  1 and cfg_ready  out  1  SHALL form the word handshake; transfer occurs when both are high on a prog_clk edge.
REQ-009 ccff_head  out  1  SHALL drive the head of the configuration chain.
REQ-010 ccff_tail  in  1  SHALL be the tail of the configuration chain.
REQ-011 shift_en  out  1  SHALL be the chain clock enable; the chain advances one bit on each edge where it is high.
REQ-012 busy  out  1, done  out  1 and err  out  1  SHALL report status.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, SHIFT, VERIFY and DONE; VERIFY exists only per REQ-029.
REQ-014 IDLE with start=1 SHALL go to FETCH on the next edge, clear bit_cnt and clear err; with start=0 it SHALL stay in IDLE.
REQ-015 cfg_ready SHALL be high only in FETCH; in FETCH, shift_en=0 and ccff_head holds its last value.
REQ-016 A FETCH handshake SHALL load cfg_data into a WORD_W shift register and go to SHIFT.
REQ-017 Without a handshake, FETCH SHALL hold indefinitely with no timeout.
REQ-018 Each SHIFT cycle SHALL assert shift_en and drive ccff_head from the shift-register MSB.
REQ-019 On each SHIFT edge the shift register SHALL shift left by one and bit_cnt SHALL increment.
REQ-020 A word accepted on edge t SHALL drive its bits in cycles t+1..t+WORD_W, MSB first.
REQ-021 The first bit of the stream SHALL be destined for the chain's far (tail) end.
REQ-022 After WORD_W bits, SHIFT SHALL return to FETCH if bit_cnt < CHAIN_LEN.
REQ-023 When bit_cnt reaches CHAIN_LEN, SHIFT SHALL leave immediately, even mid-word; the unused LSBs of the final word SHALL be discarded.
REQ-024 Exactly CHAIN_LEN shift_en cycles SHALL occur per load; bit_cnt SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE; shift_en=0 in DONE.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 abort SHALL force IDLE on the next edge with shift_en=0 and no done pulse; abort has priority over a simultaneous handshake or bit-count completion.
REQ-028 start while busy SHALL be ignored.

Configuration
REQ-029 With CCFF_READBACK_EN defined, the block SHALL accumulate the XOR parity of all bits driven in SHIFT.
REQ-030 With CCFF_READBACK_EN defined, completion of SHIFT SHALL enter VERIFY for exactly CHAIN_LEN cycles, with shift_en=1 and ccff_head=ccff_tail (recirculation restores the chain contents).
REQ-031 During VERIFY the block SHALL accumulate the parity of ccff_tail; on exit to DONE, err SHALL be set if the two parities differ, and err SHALL hold until the next accepted start.
REQ-032 Without CCFF_READBACK_EN, VERIFY and the parity logic SHALL be absent, SHIFT SHALL go directly to DONE, and err SHALL be tied to 0.

Reset
REQ-033 Asserting prog_reset SHALL immediately force the IDLE state and set bit_cnt and the shift register to 0.
REQ-034 Asserting prog_reset SHALL immediately set ccff_head, shift_en, cfg_ready, busy, done, err and both parities to 0.
REQ-035 Reset mid-load SHALL discard the partial load; the chain is then in an undefined state and requires a new start.

Verification
REQ-036 CHAIN_LEN=64, WORD_W=8, 8 words 0xA5..., cfg_valid held high -> 64 shift_en cycles, ccff_head bit sequence equals the words MSB-first, done pulses once, busy falls the cycle after done.
REQ-037 CHAIN_LEN=20, WORD_W=8, words 0xFF,0x00,0xF0 -> exactly 20 shift_en cycles; the last 4 bits of 0xF0 (the 0000) are never driven.
REQ-038 cfg_valid dropped for 5 cycles in FETCH -> shift_en=0 and cfg_ready=1 for those 5 cycles, then loading resumes with no bit lost.
REQ-039 abort asserted at bit 30 of 64 -> IDLE next cycle, no done pulse; a following start reloads all 64 bits.
REQ-040 prog_reset pulsed mid-SHIFT -> all outputs 0 immediately; in the next load, the first bit is driven the cycle after the first handshake.
REQ-041 CCFF_READBACK_EN defined, behavioral 64-bit chain model -> err=0 and chain contents unchanged after VERIFY; with one model bit flipped during VERIFY -> err=1 at done.
